dcache_miss_queue: RTL

- Parametrised non-blocking miss handler between the dcache store/lookup logic and the LSQ; successor to the single-entry read holding logic.
- Tracks up to NUM_ENT outstanding load misses and merges secondary misses to an in-flight line.
- Arbitrates evictions (priority) against load issue on the LSQ request port.
- Captures memory fills and returns extracted load data in order of lowest entry index.

---
 rtl/dcache_miss_queue.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_miss_queue.sv
// Non-blocking dcache miss queue. It tracks outstanding load misses and merges secondary
// misses to a line already in flight. It also arbitrates evictions against load issue
// and returns filled load data, lowest entry first.
module dcache_miss_queue #(
   parameter int ADDR_W  = 15,
   parameter int LINE_W  = 64,
   parameter int DATA_W  = 32,
   parameter int OFF_W   = 3,
   parameter int NUM_ENT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       miss_vld,
   input  logic [ADDR_W-1:0]          miss_addr,
   input  logic                       miss_nc,
   output logic                       miss_rdy,
   input  logic                       evict_vld,
   input  logic [ADDR_W-1:0]          evict_addr,
   input  logic [LINE_W-1:0]          evict_data,
   output logic                       evict_rdy,
   output logic                       out_vld,
   input  logic                       out_rd,
   input  logic                       lsq_full,
   output logic                       out_rdwr,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [LINE_W-1:0]          out_data,
   output logic                       out_cacheable,
   input  logic                       mem_vld,
   input  logic [ADDR_W-1:0]          mem_addr,
   input  logic [LINE_W-1:0]          mem_data,
   output logic                       mem_read,
   output logic                       resp_vld,
   input  logic                       resp_rd,
   output logic [ADDR_W-1:0]          resp_addr,
   output logic [DATA_W-1:0]          resp_data,
   output logic [$clog2(NUM_ENT):0]   occupancy
);

   localparam int IDX_W = $clog2(NUM_ENT);
   localparam int LA_W  = ADDR_W - OFF_W;

   typedef enum logic [2:0] {ST_IDLE, ST_PEND, ST_ISSUED, ST_WAIT, ST_DONE} entState_e;

   entState_e           entState_q [NUM_ENT];
   entState_e           entState_d [NUM_ENT];
   logic [ADDR_W-1:0]   entAddr_q  [NUM_ENT];
   logic [ADDR_W-1:0]   entAddr_d  [NUM_ENT];
   logic                entNc_q    [NUM_ENT];
   logic                entNc_d    [NUM_ENT];
   logic [DATA_W-1:0]   entData_q  [NUM_ENT];
   logic [DATA_W-1:0]   entData_d  [NUM_ENT];

   logic                anyIdle;
   logic                anyPend;
   logic                anyDone;
   logic                mergeHit;
   logic [IDX_W-1:0]    allocIdx;
   logic [IDX_W-1:0]    pendIdx;
   logic [IDX_W-1:0]    doneIdx;
   logic                allocFire;
   logic                issueFire;
   logic                drainFire;
   logic                allocFillHit;

   function automatic logic [LA_W-1:0] lineOf(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:OFF_W];
   endfunction

   // Byte-shift the fill line down to the load offset; bytes beyond the line end come in as zero.
   function automatic logic [DATA_W-1:0] extractWord(input logic [LINE_W-1:0] line,
                                                     input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] shifted;
      shifted = line >> {a[OFF_W-1:0], 3'b000};
      return shifted[DATA_W-1:0];
   endfunction

   // Scanning downwards leaves each index at the lowest matching entry.
   always_comb begin
      anyIdle   = 1'b0;
      anyPend   = 1'b0;
      anyDone   = 1'b0;
      mergeHit  = 1'b0;
      allocIdx  = '0;
      pendIdx   = '0;
      doneIdx   = '0;
      occupancy = '0;
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
         if (entState_q[i] == ST_IDLE) begin
            anyIdle  = 1'b1;
            allocIdx = IDX_W'(i);
         end else begin
            occupancy = occupancy + (IDX_W+1)'(1);
         end
         if (entState_q[i] == ST_PEND) begin
            anyPend = 1'b1;
            pendIdx = IDX_W'(i);
         end
         if (entState_q[i] == ST_DONE) begin
            anyDone = 1'b1;
            doneIdx = IDX_W'(i);
         end
         if (!entNc_q[i] &&
             (entState_q[i] == ST_PEND || entState_q[i] == ST_ISSUED || entState_q[i] == ST_WAIT) &&
             lineOf(entAddr_q[i]) == lineOf(miss_addr))
            mergeHit = 1'b1;
      end
   end

   assign miss_rdy     = anyIdle;
   assign mem_read     = 1'b1;
   assign allocFire    = miss_vld & anyIdle;
   assign issueFire    = anyPend & ~evict_vld & ~lsq_full & out_rd;
   assign drainFire    = anyDone & resp_rd;
   assign allocFillHit = ~miss_nc & mem_vld & (lineOf(miss_addr) == lineOf(mem_addr));

   always_comb begin
      out_vld       = (evict_vld | anyPend) & ~lsq_full;
      evict_rdy     = evict_vld & out_rd & ~lsq_full;
      out_rdwr      = 1'b0;
      out_addr      = '0;
      out_data      = '0;
      out_cacheable = 1'b0;
      resp_vld      = anyDone;
      resp_addr     = '0;
      resp_data     = '0;
      if (evict_vld) begin
         out_rdwr      = 1'b1;
         out_addr      = evict_addr;
         out_data      = evict_data;
         out_cacheable = 1'b1;
      end else if (anyPend) begin
         out_cacheable = ~entNc_q[pendIdx];
         out_addr      = entNc_q[pendIdx] ? entAddr_q[pendIdx]
                                          : {lineOf(entAddr_q[pendIdx]), {OFF_W{1'b0}}};
      end
      if (anyDone) begin
         resp_addr = entAddr_q[doneIdx];
         resp_data = entData_q[doneIdx];
      end
   end

   // An IDLE slot is only taken from registered state, so a slot drained this cycle stays free until the next.
   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         entState_d[i] = entState_q[i];
         entAddr_d[i]  = entAddr_q[i];
         entNc_d[i]    = entNc_q[i];
         entData_d[i]  = entData_q[i];
         case (entState_q[i])
            ST_IDLE: begin
               if (allocFire && allocIdx == IDX_W'(i)) begin
                  entAddr_d[i] = miss_addr;
                  entNc_d[i]   = miss_nc;
                  if (allocFillHit) begin
                     entState_d[i] = ST_DONE;
                     entData_d[i]  = extractWord(mem_data, miss_addr);
                  end else if (!miss_nc && mergeHit) begin
                     entState_d[i] = ST_WAIT;
                  end else begin
                     entState_d[i] = ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (issueFire && pendIdx == IDX_W'(i))
                  entState_d[i] = ST_ISSUED;
            end
            ST_ISSUED, ST_WAIT: begin
               if (mem_vld && lineOf(entAddr_q[i]) == lineOf(mem_addr)) begin
                  entState_d[i] = ST_DONE;
                  entData_d[i]  = extractWord(mem_data, entAddr_q[i]);
               end
            end
            ST_DONE: begin
               if (drainFire && doneIdx == IDX_W'(i))
                  entState_d[i] = ST_IDLE;
            end
            default: entState_d[i] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            entState_q[i] <= ST_IDLE;
            entAddr_q[i]  <= '0;
            entNc_q[i]    <= 1'b0;
            entData_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ENT; i++) begin
            entState_q[i] <= entState_d[i];
            entAddr_q[i]  <= entAddr_d[i];
            entNc_q[i]    <= entNc_d[i];
            entData_q[i]  <= entData_d[i];
         end
      end
   end

endmodule
